text_write_ctrl: RTL and testbench

Sequencing controller for the dual-port text RAM behind the VGA text display. It takes received UART bytes and screen-clear requests, and produces every write on the RAM write port. It owns the cursor and handles newline, backspace and wrap-around, runs a full-screen clear walk, and echoes accepted bytes to the UART transmitter through a busy handshake. It replaces ad-hoc cursor logic in the top level; the RAM read port stays with the VGA text path.

---
 rtl/text_write_ctrl_pkg.sv | 18 +
 rtl/text_write_ctrl_if.sv | 38 +++
 rtl/text_write_ctrl_cursor.sv | 49 ++++
 rtl/text_write_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_text_write_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_write_ctrl_pkg.sv
// Shared constants and types for the text RAM write controller.
// Contents: character codes, printable range bounds, FSM state encoding.
package text_ctrl_pkg;

  localparam logic [7:0] CHAR_CR       = 8'h0D;
  localparam logic [7:0] CHAR_LF       = 8'h0A;
  localparam logic [7:0] CHAR_BS       = 8'h08;
  localparam logic [7:0] CHAR_PRINT_LO = 8'h20;
  localparam logic [7:0] CHAR_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ECHO  = 2'd2,
    CLEAR = 2'd3
  } state_e;

endpackage

// File: rtl/text_write_ctrl_if.sv
// Bundle of UART-side, RAM-write-side and debug signals of text_write_ctrl.
// master: the controller (drives RAM writes, echo, cursor, status).
// slave : the surrounding system (drives rx bytes, clear requests, tx_busy).
interface text_write_ctrl_if #(
  parameter int unsigned COLS = 32,
  parameter int unsigned ROWS = 4
);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          clear_req;
  logic          tx_busy;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          ram_we;
  logic [RW-1:0] ram_row;
  logic [CW-1:0] ram_col;
  logic [7:0]    ram_wdata;
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;
  logic          busy;
  logic          overflow;

  modport master (
    input  rx_valid, rx_data, clear_req, tx_busy,
    output tx_start, tx_data, ram_we, ram_row, ram_col, ram_wdata,
           cur_row, cur_col, busy, overflow
  );

  modport slave (
    output rx_valid, rx_data, clear_req, tx_busy,
    input  tx_start, tx_data, ram_we, ram_row, ram_col, ram_wdata,
           cur_row, cur_col, busy, overflow
  );

endinterface

// File: rtl/text_write_ctrl_cursor.sv
// Cursor position register with wrap-around.
// Ports: clk, reset (async active-low); one-hot commands adv / nl / back / home;
// row, col: registered cursor position.
module text_cursor #(
  parameter int unsigned COLS = 32,
  parameter int unsigned ROWS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     adv,
  input  logic                     nl,
  input  logic                     back,
  input  logic                     home,
  output logic [$clog2(ROWS)-1:0]  row,
  output logic [$clog2(COLS)-1:0]  col
);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  // Power-of-two geometry lets row/col increments wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (home) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end else if (nl) begin
      col <= '0;
      row <= row + RW'(1);
    end else if (back) begin
      if (col != '0) begin
        col <= col - CW'(1);
      end else if (row != '0) begin
        row <= row - RW'(1);
        col <= LAST_COL;
      end
    end
  end

endmodule

// File: rtl/text_write_ctrl.sv
// Sequencing controller for the text RAM write port: buffers UART bytes,
// handles printable / CR / LF / BS, runs full-screen clears, echoes bytes.
// Ports: clk, reset (async active-low), bus (text_write_ctrl_if.master):
// rx_valid/rx_data/clear_req/tx_busy in; tx_start/tx_data, ram_we/ram_row/
// ram_col/ram_wdata, cur_row/cur_col, busy, overflow out (all registered).
module text_write_ctrl
  import text_ctrl_pkg::*;
#(
  parameter int unsigned COLS      = 32,
  parameter int unsigned ROWS      = 4,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  text_write_ctrl_if.master bus
);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned AW = CW + RW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(ROWS * COLS - 1);

  state_e        state;
  logic          pend;
  logic          clr_pend;
  logic [7:0]    rx_buf;
  logic [7:0]    echo_byte;
  logic [AW-1:0] clr_cnt;

  logic          tx_start_q;
  logic [7:0]    tx_data_q;
  logic          ram_we_q;
  logic [RW-1:0] ram_row_q;
  logic [CW-1:0] ram_col_q;
  logic [7:0]    ram_wdata_q;
  logic          busy_q;
  logic          overflow_q;
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;

  logic          consume_c;
  logic          is_print_c;
  logic          is_nl_c;
  logic          is_bs_c;
  logic          adv_c;
  logic          nl_c;
  logic          back_c;
  logic          home_c;
  logic [RW-1:0] bs_row_c;
  logic [CW-1:0] bs_col_c;

  // Byte classification, cursor commands and the backspace target address.
  always_comb begin
    consume_c  = (state == IDLE) && !clr_pend && pend;
    is_print_c = (rx_buf >= CHAR_PRINT_LO) && (rx_buf <= CHAR_PRINT_HI);
    is_nl_c    = (rx_buf == CHAR_CR) || (rx_buf == CHAR_LF);
    is_bs_c    = (rx_buf == CHAR_BS);
    adv_c      = consume_c && is_print_c;
    nl_c       = consume_c && is_nl_c;
    back_c     = consume_c && is_bs_c;
    home_c     = (state == CLEAR) && (clr_cnt == LAST_ADDR);
    bs_row_c   = cur_row;
    bs_col_c   = cur_col;
    if (cur_col != '0) begin
      bs_col_c = cur_col - CW'(1);
    end else if (cur_row != '0) begin
      bs_row_c = cur_row - RW'(1);
      bs_col_c = '1;
    end
  end

  // One-entry byte buffer, clear latch and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend       <= 1'b0;
      rx_buf     <= '0;
      clr_pend   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (home_c) begin
        clr_pend   <= 1'b0;
        overflow_q <= 1'b0;
      end else if (bus.clear_req && (state != CLEAR)) begin
        clr_pend <= 1'b1;
      end
      // A drop in the final clear cycle still flags overflow.
      if (bus.rx_valid) begin
        if (pend && !consume_c) begin
          overflow_q <= 1'b1;
        end else begin
          rx_buf <= bus.rx_data;
          pend   <= 1'b1;
        end
      end else if (consume_c) begin
        pend <= 1'b0;
      end
    end
  end

  // Main sequencer. tx_start is raised one cycle ahead of the ECHO exit so
  // that the pulse itself is registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      echo_byte   <= '0;
      clr_cnt     <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      ram_we_q    <= 1'b0;
      ram_row_q   <= '0;
      ram_col_q   <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      ram_we_q   <= 1'b0;
      tx_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_pend) begin
            state       <= CLEAR;
            busy_q      <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_row_q   <= '0;
            ram_col_q   <= '0;
            ram_wdata_q <= FILL_CHAR;
            clr_cnt     <= '0;
          end else if (pend) begin
            echo_byte <= rx_buf;
            if (is_print_c) begin
              state       <= WRITE;
              ram_we_q    <= 1'b1;
              ram_row_q   <= cur_row;
              ram_col_q   <= cur_col;
              ram_wdata_q <= rx_buf;
            end else if (is_bs_c) begin
              state       <= WRITE;
              ram_we_q    <= 1'b1;
              ram_row_q   <= bs_row_c;
              ram_col_q   <= bs_col_c;
              ram_wdata_q <= FILL_CHAR;
            end else if (is_nl_c) begin
              state <= ECHO;
              if (!bus.tx_busy) begin
                tx_start_q <= 1'b1;
                tx_data_q  <= rx_buf;
              end
            end
          end
        end
        WRITE: begin
          state <= ECHO;
          if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= echo_byte;
          end
        end
        ECHO: begin
          if (tx_start_q) begin
            state <= IDLE;
          end else if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= echo_byte;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            clr_cnt                  <= clr_cnt + AW'(1);
            ram_we_q                 <= 1'b1;
            {ram_row_q, ram_col_q}   <= clr_cnt + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  text_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk   (clk),
    .reset (reset),
    .adv   (adv_c),
    .nl    (nl_c),
    .back  (back_c),
    .home  (home_c),
    .row   (cur_row),
    .col   (cur_col)
  );

  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_row   = ram_row_q;
  assign bus.ram_col   = ram_col_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.cur_row   = cur_row;
  assign bus.cur_col   = cur_col;
  assign bus.busy      = busy_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_text_write_ctrl.sv
// Scoreboard bench for text_write_ctrl: stimulus pushes expected RAM writes
// and echoes; a negedge monitor pops and compares whenever ram_we/tx_start fire.
module tb_text_write_ctrl;

  typedef struct packed {
    logic [1:0] row;
    logic [4:0] col;
    logic [7:0] data;
  } wr_t;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  wr_t        wq[$];
  logic [7:0] eq[$];

  text_write_ctrl_if #(.COLS(32), .ROWS(4)) bus ();

  text_write_ctrl #(.COLS(32), .ROWS(4), .FILL_CHAR(8'h20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic exp_wr(input int r, input int c, input logic [7:0] d);
    wr_t w;
    w.row  = 2'(r);
    w.col  = 5'(c);
    w.data = d;
    wq.push_back(w);
  endtask

  task automatic exp_echo(input logic [7:0] d);
    eq.push_back(d);
  endtask

  // One-cycle rx pulse followed by enough idle time for full service.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // One-cycle rx pulse, next pulse may start four cycles after this one.
  task automatic pulse(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((wq.size() != 0 || eq.size() != 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", 32'(wq.size() + eq.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_cur(input string name, input int r, input int c);
    chk(name, 32'({bus.cur_row, bus.cur_col}), 32'({2'(r), 5'(c)}));
  endtask

  // Monitor: every RAM write and every echo must match the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.ram_we) begin
        if (wq.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: row %0d col %0d data %0h, none required",
                   bus.ram_row, bus.ram_col, bus.ram_wdata);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("ram_write", 32'({bus.ram_row, bus.ram_col, bus.ram_wdata}), 32'(w));
        end
      end
      if (bus.tx_start) begin
        if (eq.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_echo: data %0h, none required", bus.tx_data);
        end else begin
          logic [7:0] e;
          e = eq.pop_front();
          chk("echo_data", 32'(bus.tx_data), 32'(e));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    int cnt;
    n_pass        = 0;
    n_total       = 0;
    reset         = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.clear_req = 1'b0;
    bus.tx_busy   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_addr", 32'({bus.ram_row, bus.ram_col, bus.ram_wdata}), 32'd0);
    chk_cur("rst_cursor", 0, 0);
    reset = 1'b1;
    @(negedge clk);

    // 'A' with cycle-exact latency checks
    exp_wr(0, 0, 8'h41);
    exp_echo(8'h41);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h41;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("a_we_n1", 32'(bus.ram_we), 32'd0);
    @(negedge clk);
    chk("a_we_n2", 32'(bus.ram_we), 32'd1);
    chk_cur("a_cursor_n2", 0, 1);
    @(negedge clk);
    chk("a_tx_start_n3", 32'(bus.tx_start), 32'd1);
    drain();

    // non-printable, non-control bytes are discarded silently
    send(8'h01);
    send(8'h7F);
    drain();
    chk_cur("discard_cursor", 0, 1);

    // LF twice -> (2,0), then BS -> fill at (1,31)
    exp_echo(8'h0A); send(8'h0A);
    exp_echo(8'h0A); send(8'h0A);
    drain();
    chk_cur("lf_cursor", 2, 0);
    exp_wr(1, 31, 8'h20); exp_echo(8'h08); send(8'h08);
    drain();
    chk_cur("bs_row_wrap", 1, 31);

    // into row 3 then 32 printable bytes, wrap to (0,0)
    exp_echo(8'h0A); send(8'h0A);
    exp_echo(8'h0A); send(8'h0A);
    drain();
    chk_cur("row3_start", 3, 0);
    for (int i = 0; i < 32; i++) begin
      exp_wr(3, i, 8'(8'h30 + i));
      exp_echo(8'(8'h30 + i));
      send(8'(8'h30 + i));
    end
    drain();
    chk_cur("full_wrap", 0, 0);

    // BS at origin stays put
    exp_wr(0, 0, 8'h20); exp_echo(8'h08); send(8'h08);
    drain();
    chk_cur("bs_origin", 0, 0);

    // reach (1,5), then CR and LF without writes
    exp_echo(8'h0A); send(8'h0A);
    for (int i = 0; i < 5; i++) begin
      exp_wr(1, i, 8'(8'h61 + i));
      exp_echo(8'(8'h61 + i));
      send(8'(8'h61 + i));
    end
    drain();
    chk_cur("pos_1_5", 1, 5);
    exp_echo(8'h0D); send(8'h0D);
    drain();
    chk_cur("cr_cursor", 2, 0);
    exp_echo(8'h0A); send(8'h0A);
    drain();
    chk_cur("lf2_cursor", 3, 0);

    // simultaneous clear and 'Z': clear first, then 'Z' at (0,0)
    for (int a = 0; a < 128; a++) exp_wr(a / 32, a % 32, 8'h20);
    exp_wr(0, 0, 8'h5A);
    exp_echo(8'h5A);
    @(negedge clk);
    bus.clear_req = 1'b1;
    bus.rx_valid  = 1'b1;
    bus.rx_data   = 8'h5A;
    @(negedge clk);
    bus.clear_req = 1'b0;
    bus.rx_valid  = 1'b0;
    chk("clr_busy_n1", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("clr_busy_n2", 32'(bus.busy), 32'd1);
    cnt = 0;
    while (bus.busy && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    chk("clr_busy_cycles", 32'(cnt), 32'd128);
    chk_cur("clr_home", 0, 0);
    chk("clr_overflow", 32'(bus.overflow), 32'd0);
    drain();
    chk_cur("after_z", 0, 1);

    // tx_busy held: byte 1 waits, byte 2 buffered, byte 3 dropped
    bus.tx_busy = 1'b1;
    exp_wr(0, 1, 8'h70); exp_echo(8'h70);
    exp_wr(0, 2, 8'h71); exp_echo(8'h71);
    pulse(8'h70);
    pulse(8'h71);
    chk("ovf_before_drop", 32'(bus.overflow), 32'd0);
    pulse(8'h72);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk_cur("ovf_cursor_wait", 0, 2);
    bus.tx_busy = 1'b0;
    drain();
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    chk_cur("ovf_cursor_done", 0, 3);

    // reset mid-clear aborts the walk
    for (int a = 0; a < 128; a++) exp_wr(a / 32, a % 32, 8'h20);
    @(negedge clk);
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    repeat (20) @(negedge clk);
    chk("midclr_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_overflow", 32'(bus.overflow), 32'd0);
    chk("midrst_addr", 32'({bus.ram_row, bus.ram_col, bus.ram_wdata}), 32'd0);
    chk("midrst_tx", 32'({bus.tx_start, bus.tx_data}), 32'd0);
    chk_cur("midrst_cursor", 0, 0);
    wq.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("left_writes", 32'(wq.size()), 32'd0);
    chk("left_echoes", 32'(eq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
